seg7_mux_decoder: RTL and testbench
===================================

// Module: seg7_mux_decoder
// PURPOSE
//  Receive side of the 2-digit multiplexed 7-segment PMOD link (seg[6:0] plus one digit-select line).
//  Samples the time-multiplexed pins and waits for each digit to settle.
//  Decodes each settled pattern back to a hex nibble and holds both digits as registered outputs.
//  Used for loopback self-test and for monitoring an external display driver.
// PARAMETERS
//  CLK_IN         80_000_000  clk frequency, Hz
//  COMMON_ANODE   1           1: pins active-low (inverted before decode); 0: active-high
//  SETTLE_CYCLES  16          cycles seg must be stable after a sel edge before capture (>=2)
//  TIMEOUT_MS     10          ms without a sel edge before the link is declared dead
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active-low
//  seg_in      in   7  segment pins, bit0=a .. bit6=g, asynchronous to clk
//  sel_in      in   1  digit select pin; 0 = digit 1, 1 = digit 2; asynchronous
//  digit1      out  4  last valid nibble captured while sel=0
//  digit2      out  4  last valid nibble captured while sel=1
//  digit1_vld  out  1  digit1 holds a valid decode
//  digit2_vld  out  1  digit2 holds a valid decode
//  upd         out  1  1-cycle pulse on every capture, valid or not
//  upd_slot    out  1  slot of the last capture (0 = digit 1, 1 = digit 2), held between captures
//  dec_err     out  1  1-cycle pulse: settled pattern is not in the hex table
//  link_ok     out  1  sel edges seen within the timeout window
//  err_cnt     out  8  only with SEG7_DEC_ERRCNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every output is 0 and the FSM is in IDLE.
//  - Input stage: seg_in and sel_in each pass through a 2-flop synchronizer.
//    seg_n = COMMON_ANODE ? ~seg_s : seg_s.
//    A sel edge is sel_s != sel_s delayed by one cycle.
//  - FSM states: IDLE, SETTLE, CAPTURE, HOLD.
//    IDLE: on a sel edge -> SETTLE; latch slot = new sel_s; clear the settle count.
//    SETTLE: if seg_n differs from its previous-cycle value, the count restarts at 0.
//      When the count reaches SETTLE_CYCLES-1 with seg_n unchanged -> CAPTURE.
//    CAPTURE (1 cycle): decode seg_n.
//      Hit: write the nibble to digit[slot] and set vld[slot].
//      Miss: pulse dec_err and clear vld[slot]; the previous nibble is retained.
//      Either case: pulse upd, set upd_slot = slot, then -> HOLD.
//    HOLD: wait; on a sel edge -> SETTLE with the new slot.
//  - A sel edge in SETTLE or CAPTURE aborts the capture in progress.
//    Nothing is written, the FSM goes to SETTLE with the new slot, and the count restarts.
//  - Capture latency: digit and upd update 2 (sync) + SETTLE_CYCLES + 1 cycles after the last pin change.
//  - Decode table (active-high, g..a), patterns 0..F:
//      3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
//    Any other value, including blank 00, is a miss.
//  - Timeout: TO_CYC = CLK_IN/1000*TIMEOUT_MS.
//    The timeout counter clears on every sel edge and saturates at TO_CYC.
//    On reaching TO_CYC: link_ok=0, digit1_vld and digit2_vld cleared (nibbles held), FSM -> IDLE.
//    link_ok is set on the first sel edge after reset or after a timeout.
//  - Timeout and sel edge in the same cycle: the edge wins (counter clears, link stays ok).
//  - An asynchronous reset mid-capture discards the capture and returns every output to its reset value.
// CONFIGURATION
//  SEG7_DEC_ERRCNT_EN defined:
//    err_cnt[7:0] port exists.
//    It increments on each dec_err pulse, saturates at 255, and clears only on reset.
//  Macro undefined: err_cnt port and its counter are absent; all other behaviour is unchanged.
// STRUCTURE
//  seg7_pkg (shared package):
//    state enum (IDLE/SETTLE/CAPTURE/HOLD)
//    SEG_HEX[16] pattern constant table
//    function seg_decode(input [6:0] p, output hit, output [3:0] nib)
//  Sub-module seg7_sync: parameterised-width 2-flop synchronizer, instantiated for seg_in and sel_in.
// TESTING (CLK_IN=1_000_000, SETTLE_CYCLES=4, TIMEOUT_MS=1, COMMON_ANODE=1)
//  1. Alternate sel every 100 cyc, slot0 pins ~7'h4F, slot1 pins ~7'h71
//     -> digit1=3, digit2=F, both vld=1, upd pulses once per sel edge, link_ok=1.
//  2. After sel edge, change seg every 3 cyc for 12 cyc, then hold ~7'h06
//     -> single capture of 1 exactly 2+4+1 cyc after the last change.
//  3. Slot0 pins ~7'h00 (blank)
//     -> dec_err pulse, digit1_vld=0, digit1 retains prior value; err_cnt +1 if macro set.
//  4. Sel edge 2 cyc into SETTLE -> no upd for the aborted slot; capture lands in the new slot.
//  5. Stop toggling sel for 1000 cyc
//     -> link_ok falls at cycle 1000, both vld=0; next sel edge re-raises link_ok.
//  6. Assert rst_n low mid-SETTLE -> all outputs 0 immediately; no upd after release until a new edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared state encoding, hex segment table and pattern decoder for the 7-segment receive path.
// Patterns are active-high, bit0=a .. bit6=g.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic void seg_decode(input logic [6:0] p, output logic hit, output logic [3:0] nib);
        hit = 1'b0;
        nib = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (SEG_HEX[i] == p) begin
                hit = 1'b1;
                nib = 4'(i);
            end
        end
    endfunction

endpackage

// File: rtl/seg7_sync.sv
// Two-flop synchronizer for asynchronous pins, W bits wide; 2-cycle latency, no backpressure.
// Each bit is synchronized independently, so multi-bit buses need a downstream settle check.
module seg7_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/seg7_mux_decoder.sv
// Receive side of a 2-digit multiplexed 7-segment link; digits/upd land 2+SETTLE_CYCLES+1 cycles after the last pin change.
// No backpressure: free-running capture. SEG7_DEC_ERRCNT_EN adds the saturating err_cnt port.
module seg7_mux_decoder
    import seg7_pkg::*;
#(
    parameter int CLK_IN        = 80_000_000,
    parameter int COMMON_ANODE  = 1,
    parameter int SETTLE_CYCLES = 16,
    parameter int TIMEOUT_MS    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       sel_in,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic       digit1_vld,
    output logic       digit2_vld,
    output logic       upd,
    output logic       upd_slot,
    output logic       dec_err,
    output logic       link_ok
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int TO_CYC = CLK_IN / 1000 * TIMEOUT_MS;
    localparam int TW     = $clog2(TO_CYC + 1);
    localparam int CW     = $clog2(SETTLE_CYCLES);

    localparam logic [TW-1:0] TO_MAX   = TW'(TO_CYC);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 2);

    logic [6:0] seg_s;
    logic       sel_s;
    logic [6:0] seg_n;
    logic       sel_edge;
    logic       seg_chg;
    logic       to_hit;
    logic       dec_hit;
    logic [3:0] dec_nib;

    state_e        state_q, state_d;
    logic          slot_q, slot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          sel_q;
    logic [6:0]    seg_prev_q;
    logic          link_ok_q, link_ok_d;
    logic [3:0]    digit1_q, digit1_d;
    logic [3:0]    digit2_q, digit2_d;
    logic          vld1_q, vld1_d;
    logic          vld2_q, vld2_d;
    logic          upd_q, upd_d;
    logic          upd_slot_q, upd_slot_d;
    logic          dec_err_q, dec_err_d;

    seg7_sync #(.W(7)) u_seg_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (seg_in),
        .q_o   (seg_s)
    );

    seg7_sync #(.W(1)) u_sel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sel_in),
        .q_o   (sel_s)
    );

    assign seg_n    = (COMMON_ANODE != 0) ? ~seg_s : seg_s;
    assign sel_edge = sel_s != sel_q;
    assign seg_chg  = seg_n != seg_prev_q;
    // A sel edge in the same cycle always beats the timeout.
    assign to_hit   = !sel_edge && (to_cnt_q == TO_LAST);

    always_comb begin
        seg_decode(seg_n, dec_hit, dec_nib);
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        to_cnt_d   = to_cnt_q;
        link_ok_d  = link_ok_q;
        digit1_d   = digit1_q;
        digit2_d   = digit2_q;
        vld1_d     = vld1_q;
        vld2_d     = vld2_q;
        upd_d      = 1'b0;
        upd_slot_d = upd_slot_q;
        dec_err_d  = 1'b0;

        case (state_q)
            IDLE: ;
            SETTLE: begin
                // The cycle a new pattern appears counts as its first stable cycle.
                if (seg_chg) begin
                    cnt_d = '0;
                end else if (cnt_q == SET_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                state_d = HOLD;
                if (!sel_edge && !to_hit) begin
                    upd_d      = 1'b1;
                    upd_slot_d = slot_q;
                    if (dec_hit) begin
                        if (slot_q) begin
                            digit2_d = dec_nib;
                            vld2_d   = 1'b1;
                        end else begin
                            digit1_d = dec_nib;
                            vld1_d   = 1'b1;
                        end
                    end else begin
                        dec_err_d = 1'b1;
                        if (slot_q) vld2_d = 1'b0;
                        else        vld1_d = 1'b0;
                    end
                end
            end
            HOLD: ;
            default: state_d = IDLE;
        endcase

        if (sel_edge) begin
            state_d   = SETTLE;
            slot_d    = sel_s;
            cnt_d     = '0;
            to_cnt_d  = '0;
            link_ok_d = 1'b1;
        end else begin
            if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
            if (to_hit) begin
                state_d   = IDLE;
                link_ok_d = 1'b0;
                vld1_d    = 1'b0;
                vld2_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            slot_q     <= 1'b0;
            cnt_q      <= '0;
            to_cnt_q   <= '0;
            sel_q      <= 1'b0;
            seg_prev_q <= '0;
            link_ok_q  <= 1'b0;
            digit1_q   <= '0;
            digit2_q   <= '0;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
            upd_q      <= 1'b0;
            upd_slot_q <= 1'b0;
            dec_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            to_cnt_q   <= to_cnt_d;
            sel_q      <= sel_s;
            seg_prev_q <= seg_n;
            link_ok_q  <= link_ok_d;
            digit1_q   <= digit1_d;
            digit2_q   <= digit2_d;
            vld1_q     <= vld1_d;
            vld2_q     <= vld2_d;
            upd_q      <= upd_d;
            upd_slot_q <= upd_slot_d;
            dec_err_q  <= dec_err_d;
        end
    end

`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (dec_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign digit1     = digit1_q;
    assign digit2     = digit2_q;
    assign digit1_vld = vld1_q;
    assign digit2_vld = vld2_q;
    assign upd        = upd_q;
    assign upd_slot   = upd_slot_q;
    assign dec_err    = dec_err_q;
    assign link_ok    = link_ok_q;

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed bench for seg7_mux_decoder: vector table for steady-state decode, hand sequences for latency/abort/timeout/reset.
module tb_seg7_mux_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       sel_in;
    logic [3:0] digit1, digit2;
    logic       digit1_vld, digit2_vld, upd, upd_slot, dec_err, link_ok;
`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    seg7_mux_decoder #(
        .CLK_IN        (1_000_000),
        .COMMON_ANODE  (1),
        .SETTLE_CYCLES (4),
        .TIMEOUT_MS    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .sel_in     (sel_in),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit1_vld (digit1_vld),
        .digit2_vld (digit2_vld),
        .upd        (upd),
        .upd_slot   (upd_slot),
        .dec_err    (dec_err),
        .link_ok    (link_ok)
`ifdef SEG7_DEC_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    typedef struct {
        logic       sel;
        logic [6:0] pat;
        logic [3:0] d1;
        logic [3:0] d2;
        logic       v1;
        logic       v2;
        int         nerr;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
        if (upd === 1'b1) upd_seen++;
        if (dec_err === 1'b1) err_seen++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        int u0;
        int e0;
        int exp_errs;

        vecs[0]  = '{1'b1, 7'h71, 4'h0, 4'hF, 1'b0, 1'b1, 0};
        vecs[1]  = '{1'b0, 7'h4F, 4'h3, 4'hF, 1'b1, 1'b1, 0};
        vecs[2]  = '{1'b1, 7'h71, 4'h3, 4'hF, 1'b1, 1'b1, 0};
        vecs[3]  = '{1'b0, 7'h4F, 4'h3, 4'hF, 1'b1, 1'b1, 0};
        vecs[4]  = '{1'b1, 7'h5E, 4'h3, 4'hD, 1'b1, 1'b1, 0};
        vecs[5]  = '{1'b0, 7'h00, 4'h3, 4'hD, 1'b0, 1'b1, 1};
        vecs[6]  = '{1'b1, 7'h7F, 4'h3, 4'h8, 1'b0, 1'b1, 0};
        vecs[7]  = '{1'b0, 7'h6F, 4'h9, 4'h8, 1'b1, 1'b1, 0};
        vecs[8]  = '{1'b1, 7'h40, 4'h9, 4'h8, 1'b1, 1'b0, 1};
        vecs[9]  = '{1'b0, 7'h77, 4'hA, 4'h8, 1'b1, 1'b0, 0};
        vecs[10] = '{1'b1, 7'h3F, 4'hA, 4'h0, 1'b1, 1'b1, 0};

        rst_n  = 1'b0;
        sel_in = 1'b0;
        seg_in = 7'h7F;
        repeat (3) tick();
        chk("reset_outputs", {digit1, digit2, digit1_vld, digit2_vld, upd, upd_slot, dec_err, link_ok}, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_link_ok", link_ok, 0);
        chk("idle_no_upd", upd_seen, 0);

        exp_errs = 0;
        for (int i = 0; i < 11; i++) begin
            u0 = upd_seen;
            e0 = err_seen;
            sel_in = vecs[i].sel;
            seg_in = ~vecs[i].pat;
            repeat (100) tick();
            chk($sformatf("v%0d_digits", i), {digit1, digit2, digit1_vld, digit2_vld},
                {vecs[i].d1, vecs[i].d2, vecs[i].v1, vecs[i].v2});
            chk($sformatf("v%0d_upd_cnt", i), upd_seen - u0, 1);
            chk($sformatf("v%0d_upd_slot", i), upd_slot, vecs[i].sel);
            chk($sformatf("v%0d_dec_err_cnt", i), err_seen - e0, vecs[i].nerr);
            chk($sformatf("v%0d_link_ok", i), link_ok, 1);
            exp_errs += vecs[i].nerr;
        end
`ifdef SEG7_DEC_ERRCNT_EN
        chk("err_cnt", err_cnt, exp_errs);
`endif

        // Capture latency: patterns change every 3 cycles, then 1 is held.
        u0 = upd_seen;
        sel_in = 1'b0;
        seg_in = ~7'h5B; repeat (3) tick();
        seg_in = ~7'h66; repeat (3) tick();
        seg_in = ~7'h6D; repeat (3) tick();
        seg_in = ~7'h7D; repeat (3) tick();
        seg_in = ~7'h06;
        repeat (6) tick();
        chk("lat_no_early_upd", upd_seen - u0, 0);
        tick();
        chk("lat_upd_at_7", upd, 1);
        chk("lat_digit1", digit1, 1);
        repeat (10) tick();
        chk("lat_single_capture", upd_seen - u0, 1);

        // Abort: second sel edge 2 cycles after the first.
        u0 = upd_seen;
        sel_in = 1'b1; seg_in = ~7'h7C; repeat (2) tick();
        sel_in = 1'b0; seg_in = ~7'h39; repeat (30) tick();
        chk("abort_upd_cnt", upd_seen - u0, 1);
        chk("abort_upd_slot", upd_slot, 0);
        chk("abort_digits", {digit1, digit2, digit1_vld, digit2_vld}, {4'hC, 4'h0, 1'b1, 1'b1});

        // Timeout after 1000 cycles without a sel edge.
        sel_in = 1'b1; seg_in = ~7'h06;
        repeat (1002) tick();
        chk("to_before_link_ok", link_ok, 1);
        chk("to_before_vld", {digit1_vld, digit2_vld}, 2'b11);
        tick();
        chk("to_link_ok", link_ok, 0);
        chk("to_vld_cleared", {digit1_vld, digit2_vld}, 2'b00);
        chk("to_nibbles_held", {digit1, digit2}, {4'hC, 4'h1});
        sel_in = 1'b0; seg_in = ~7'h39;
        repeat (2) tick();
        chk("relink_early", link_ok, 0);
        tick();
        chk("relink", link_ok, 1);
        repeat (10) tick();
        chk("relink_capture", {digit1, digit1_vld, digit2_vld}, {4'hC, 1'b1, 1'b0});

        // Asynchronous reset while in SETTLE.
        sel_in = 1'b1; seg_in = ~7'h6D;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {digit1, digit2, digit1_vld, digit2_vld, upd, upd_slot, dec_err, link_ok}, 0);
`ifdef SEG7_DEC_ERRCNT_EN
        chk("midreset_err_cnt", err_cnt, 0);
`endif
        sel_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        u0 = upd_seen;
        repeat (20) tick();
        chk("post_reset_no_upd", upd_seen - u0, 0);
        chk("post_reset_link", link_ok, 0);
        sel_in = 1'b1; seg_in = ~7'h6D;
        repeat (10) tick();
        chk("post_reset_upd", upd_seen - u0, 1);
        chk("post_reset_digits", {digit1, digit2, digit1_vld, digit2_vld, link_ok},
            {4'h0, 4'h5, 1'b0, 1'b1, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
